// File: rtl/memory_if.sv
// Bus bundle for the byte-addressable memory.
//   inp_address   : byte address of the lowest byte of the word (Addr_W+1 bits)
//   inp_data      : write data, little-endian, 8*W bits
//   write_enable  : 1 = store inp_data on the next rising clock edge
//   out_read_data : combinational read data for inp_address
// The master drives the address, data and enable. The slave (the memory) drives the read data.
interface memory_if #(
   parameter int W      = 1,
   parameter int Addr_W = 8
);
   logic [Addr_W:0]  inp_address;
   logic [8*W-1:0]   inp_data;
   logic             write_enable;
   logic [8*W-1:0]   out_read_data;

   modport master (
      output inp_address,
      output inp_data,
      output write_enable,
      input  out_read_data
   );

   modport slave (
      input  inp_address,
      input  inp_data,
      input  write_enable,
      output out_read_data
   );
endinterface

// File: rtl/memory.sv
// Byte-addressable memory with a W-byte little-endian word port.
//   clk      : single clock. All state changes happen on the rising edge.
//   reset_n  : synchronous, active-low. On a reset edge every byte is cleared and the write is blocked.
//   bus      : memory_if slave port (address, write data, write enable, read data)
// Word byte k is located at (inp_address + k) mod DEPTH, so a word near the top of the array
// wraps around to location 0. Words that overlap share storage.
// Reads are asynchronous and do not bypass the write data. A write first becomes visible
// after the edge that stores it.
module memory #(
   parameter int W      = 1,
   parameter int Addr_W = 8
) (
   input  logic      clk,
   input  logic      reset_n,
   memory_if.slave   bus
);
   localparam int ADDR_BITS = Addr_W + 1;
   localparam int DEPTH     = 2 ** ADDR_BITS;

   logic [7:0]       mem [DEPTH];
   logic [8*W-1:0]   rd_word;

   // The address sum is truncated to the address width, which gives the mod-DEPTH wrap.
   function automatic logic [Addr_W:0] byte_addr(input logic [Addr_W:0] base, input int k);
      return base + ADDR_BITS'(k);
   endfunction

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         mem <= '{default: 8'h00};
      end else if (bus.write_enable) begin
         for (int k = 0; k < W; k++) begin
            mem[byte_addr(bus.inp_address, k)] <= bus.inp_data[8*k +: 8];
         end
      end
   end

   always_comb begin
      rd_word = '0;
      for (int k = 0; k < W; k++) begin
         rd_word[8*k +: 8] = mem[byte_addr(bus.inp_address, k)];
      end
   end

   assign bus.out_read_data = rd_word;
endmodule

// File: tb/tb_memory.sv
module tb_memory;
   logic clk;
   logic rst1_n;
   logic rst4_n;
   int   total;
   int   bad;

   memory_if #(.W(1), .Addr_W(8)) if1 ();
   memory_if #(.W(4), .Addr_W(8)) if4 ();

   memory #(.W(1), .Addr_W(8)) dut1 (.clk(clk), .reset_n(rst1_n), .bus(if1));
   memory #(.W(4), .Addr_W(8)) dut4 (.clk(clk), .reset_n(rst4_n), .bus(if4));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic write1(input logic [8:0] a, input logic [7:0] d);
      @(negedge clk);
      if1.inp_address  = a;
      if1.inp_data     = d;
      if1.write_enable = 1'b1;
      @(posedge clk);
      #1;
      if1.write_enable = 1'b0;
   endtask

   task automatic write4(input logic [8:0] a, input logic [31:0] d);
      @(negedge clk);
      if4.inp_address  = a;
      if4.inp_data     = d;
      if4.write_enable = 1'b1;
      @(posedge clk);
      #1;
      if4.write_enable = 1'b0;
   endtask

   task automatic test_reset;
      logic [8:0] addrs [3];
      addrs = '{9'h000, 9'h0FF, 9'h1FF};
      @(negedge clk);
      rst1_n = 1'b0;
      rst4_n = 1'b0;
      @(posedge clk);
      #1;
      rst1_n = 1'b1;
      rst4_n = 1'b1;
      foreach (addrs[i]) begin
         if1.inp_address = addrs[i];
         #1;
         total++;
         if (if1.out_read_data !== 8'h00) begin
            bad++;
            $display("FAIL reset_read1 addr=%h got=%h exp=00", addrs[i], if1.out_read_data);
         end
         if4.inp_address = addrs[i];
         #1;
         total++;
         if (if4.out_read_data !== 32'h0) begin
            bad++;
            $display("FAIL reset_read4 addr=%h got=%h exp=00000000", addrs[i], if4.out_read_data);
         end
      end
   endtask

   task automatic test_write_read;
      logic [7:0] exp_d [4];
      exp_d = '{8'h01, 8'h23, 8'h45, 8'h67};
      for (int i = 0; i < 4; i++) write1(9'(i), exp_d[i]);
      for (int i = 0; i < 4; i++) begin
         if1.inp_address = 9'(i);
         #1;
         total++;
         if (if1.out_read_data !== exp_d[i]) begin
            bad++;
            $display("FAIL write_read addr=%0d got=%h exp=%h", i, if1.out_read_data, exp_d[i]);
         end
      end
      repeat (100) @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
         if1.inp_address = 9'(i);
         #1;
         total++;
         if (if1.out_read_data !== exp_d[i]) begin
            bad++;
            $display("FAIL hold addr=%0d got=%h exp=%h", i, if1.out_read_data, exp_d[i]);
         end
      end
   endtask

   task automatic test_no_write;
      @(negedge clk);
      if1.write_enable = 1'b0;
      if1.inp_address  = 9'h002;
      if1.inp_data     = 8'hFF;
      repeat (10) @(posedge clk);
      #1;
      total++;
      if (if1.out_read_data !== 8'h45) begin
         bad++;
         $display("FAIL no_write got=%h exp=45", if1.out_read_data);
      end
   endtask

   task automatic test_wrap;
      logic [8:0]  a   [4];
      logic [7:0]  b   [4];
      a = '{9'h1FE, 9'h1FF, 9'h000, 9'h001};
      b = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
      write4(9'h1FE, 32'hDDCCBBAA);
      for (int i = 0; i < 4; i++) begin
         if4.inp_address = a[i];
         #1;
         total++;
         if (if4.out_read_data[7:0] !== b[i]) begin
            bad++;
            $display("FAIL wrap_byte addr=%h got=%h exp=%h", a[i], if4.out_read_data[7:0], b[i]);
         end
      end
      if4.inp_address = 9'h1FE;
      #1;
      total++;
      if (if4.out_read_data !== 32'hDDCCBBAA) begin
         bad++;
         $display("FAIL wrap_word got=%h exp=DDCCBBAA", if4.out_read_data);
      end
      if4.inp_address = 9'h000;
      #1;
      total++;
      if (if4.out_read_data !== 32'h0000DDCC) begin
         bad++;
         $display("FAIL wrap_word0 got=%h exp=0000DDCC", if4.out_read_data);
      end
   endtask

   task automatic test_overlap;
      write4(9'h010, 32'h44332211);
      if4.inp_address = 9'h012;
      #1;
      total++;
      if (if4.out_read_data !== 32'h00004433) begin
         bad++;
         $display("FAIL overlap_rd got=%h exp=00004433", if4.out_read_data);
      end
      write4(9'h012, 32'h0000BEEF);
      if4.inp_address = 9'h010;
      #1;
      total++;
      if (if4.out_read_data !== 32'hBEEF2211) begin
         bad++;
         $display("FAIL overlap_wr got=%h exp=BEEF2211", if4.out_read_data);
      end
      if4.inp_address = 9'h014;
      #1;
      total++;
      if (if4.out_read_data !== 32'h00000000) begin
         bad++;
         $display("FAIL overlap_hi got=%h exp=00000000", if4.out_read_data);
      end
   endtask

   task automatic test_back_to_back;
      write1(9'h005, 8'h11);
      @(negedge clk);
      if1.inp_address  = 9'h005;
      if1.inp_data     = 8'h22;
      if1.write_enable = 1'b1;
      #1;
      total++;
      if (if1.out_read_data !== 8'h11) begin
         bad++;
         $display("FAIL rdw_before got=%h exp=11", if1.out_read_data);
      end
      @(posedge clk);
      #1;
      if1.write_enable = 1'b0;
      total++;
      if (if1.out_read_data !== 8'h22) begin
         bad++;
         $display("FAIL rdw_after got=%h exp=22", if1.out_read_data);
      end
      for (int i = 4; i <= 6; i += 2) begin
         if1.inp_address = 9'(i);
         #1;
         total++;
         if (if1.out_read_data !== 8'h00) begin
            bad++;
            $display("FAIL neighbour addr=%0d got=%h exp=00", i, if1.out_read_data);
         end
      end
   endtask

   task automatic test_reset_dominates;
      @(negedge clk);
      rst1_n           = 1'b0;
      if1.write_enable = 1'b1;
      if1.inp_data     = 8'h99;
      if1.inp_address  = 9'h000;
      @(posedge clk);
      #1;
      rst1_n           = 1'b1;
      if1.write_enable = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if1.inp_address = 9'(i);
         #1;
         total++;
         if (if1.out_read_data !== 8'h00) begin
            bad++;
            $display("FAIL reset_mid addr=%0d got=%h exp=00", i, if1.out_read_data);
         end
      end
   endtask

   initial begin
      total            = 0;
      bad              = 0;
      rst1_n           = 1'b1;
      rst4_n           = 1'b1;
      if1.inp_address  = '0;
      if1.inp_data     = '0;
      if1.write_enable = 1'b0;
      if4.inp_address  = '0;
      if4.inp_data     = '0;
      if4.write_enable = 1'b0;
      test_reset();
      test_write_read();
      test_no_write();
      test_wrap();
      test_overlap();
      test_back_to_back();
      test_reset_dominates();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
